data_mux_sync: RTL
==================

// Module: data_mux_sync
// PURPOSE
// Successor to the fixed 16:1 link data mux. Selects one of N_INPUTS AXIS data streams onto a
// single output stream, inserts idle words after linkReset, and substitutes a header (or BX0
// header) on orbitSync. New over the previous generation:
// - select changes take effect only at orbit or linkReset boundaries;
// - fast-control pulses are never lost under backpressure;
// - 2-entry output skid buffer;
// - BX counter with orbit-length check.
// PARAMETERS
// DATA_WIDTH          32    width of every data word
// N_INPUTS            16    number of input streams (>=2)
// SEL_WIDTH           $clog2(N_INPUTS)  width of output_select
// IDLE_CNT_WIDTH      16    width of n_idle_words / idle countdown
// ORBIT_LEN           3564  expected accepted beats per orbit
// OUTPUT_REVERSE_BITS 1     1: tdata_out[i] = word[DATA_WIDTH-1-i]; 0: no reversal
// PORTS
// clk            in   1                     clock
// aresetn        in   1                     reset, synchronous, active-low
// tdata_in       in   DATA_WIDTH x N_INPUTS input stream data
// tvalid_in      in   1 x N_INPUTS          input stream valid
// tready_in      out  1 x N_INPUTS          input stream ready (all equal)
// tdata_out      out  DATA_WIDTH            output data
// tvalid_out     out  1                     output valid
// tready_out     in   1                     output ready
// n_idle_words   in   IDLE_CNT_WIDTH        idle words sent after a linkReset
// output_select  in   SEL_WIDTH             requested input index
// idle_word, idle_word_BX0, header_mask, header, header_BX0   in  DATA_WIDTH  patterns
// fc_orbitSync   in   1                     orbit sync (level; rising edge is the event)
// fc_linkReset   in   1                     link reset (level; rising edge is the event)
// clear_status   in   1                     1-cycle pulse; clears orbit_err
// active_select  out  SEL_WIDTH             select currently in use
// bx_count       out  12                    accepted beats since last orbit event
// orbit_err      out  1                     sticky: orbit event arrived with bx_count != ORBIT_LEN-1
// BEHAVIOUR
// Reset (aresetn=0 at posedge clk):
// - tvalid_out=0, tdata_out=0, tready_in=0;
// - skid buffer empty; idle countdown=0; pending flags=0;
// - active_select=0, bx_count=0, orbit_err=0;
// - edge-detect registers load current fc_* values, so a level already high gives no event.
// Handshake:
// - adv = skid buffer has <=1 entry; tready_in[i]=adv for all i (all links advance together).
// - Each adv cycle produces exactly one beat candidate. It is written to the buffer when its
//   valid is 1; a valid=0 candidate is dropped.
// - tvalid_out = buffer non-empty; an entry pops when tvalid_out && tready_out.
// - Latency: a candidate on an adv cycle N with the buffer empty appears on tdata_out at N+1.
// - Buffer full (2 entries) -> adv=0 until a pop. No word is lost or duplicated.
// Fast-control events:
// - Edge detectors sample fc_* every cycle.
// - A rising edge sets orbit_pend / reset_pend; the flag clears on the next adv cycle.
// - Edges arriving while stalled are therefore held, not lost.
// Countdown and select latch, applied on an adv cycle with reset_pend:
// - countdown <= n_idle_words; active_select <= output_select.
// - A new linkReset during an idle run reloads the countdown.
// - On an adv cycle with orbit_pend and countdown==0: active_select <= output_select.
// - output_select changes at any other time are ignored until the next event.
// Candidate selection, per adv cycle:
// - If countdown!=0 after the load above: send idle word (idle_word_BX0 if orbit_pend, else
//   idle_word) with valid=1, then decrement the countdown.
// - n_idle_words=0: no idle words are sent.
// - If active_select >= N_INPUTS: send idle_word with valid=1.
// - Otherwise d = tdata_in[sel]; word = (d & ~header_mask) | (H & header_mask), where
//   H = header_BX0 if orbit_pend, else header; valid = tvalid_in[sel].
// - Bit reversal is applied when the candidate is written to the buffer.
// BX counter:
// - Increments (saturating at 4095) on each candidate written to the buffer.
// - On the adv cycle consuming orbit_pend: if bx_count != ORBIT_LEN-1, orbit_err <= 1;
//   then bx_count <= 0, or <= 1 if that cycle's candidate is written to the buffer.
// - The first orbit event after reset is exempt from the check.
// - clear_status clears orbit_err; a simultaneous new error wins (orbit_err stays 1).
// TESTING
// 1. Reset: aresetn=0 for 3 cycles -> tvalid_out=0, tready_in=0, bx_count=0; first beat after
//    release appears 1 cycle after the first adv cycle.
// 2. Passthrough: sel=5, header_mask=0xF0000000, header=0xA0000000, tdata_in[5]=0x01234567,
//    REVERSE=0 -> 0xA1234567 each beat; fc_orbitSync edge -> exactly one beat with header_BX0 nibble.
// 3. linkReset with n_idle_words=4 -> exactly 4 idle_word beats, then the stream from the newly
//    latched output_select; with n_idle_words=0 -> no idle beats.
// 4. Backpressure: tready_out=0 for 10 cycles while an orbitSync edge occurs -> tready_in drops
//    after 2 buffered beats; after release the BX0 header appears exactly once, with no loss.
// 5. Select change mid-orbit from 2 to 7 -> output stays on input 2 until the next orbitSync edge;
//    sel=N_INPUTS (if representable) -> idle_word with valid=1.
// 6. Orbit check: ORBIT_LEN=8, orbit edges 8 beats apart -> orbit_err=0; 6 beats apart ->
//    orbit_err=1 until clear_status. Bit reversal: REVERSE=1 with input 0x00000001 -> 0x80000000.

Source files
------------

// File: rtl/data_mux_sync_if.sv
// Stream bundle for data_mux_sync: N input AXIS-style lanes and one output lane.
// The mux is the slave of this bundle; the driving environment is the master.
interface data_mux_sync_if #(
  parameter int DATA_WIDTH = 32,
  parameter int N_INPUTS   = 16
);
  logic [N_INPUTS-1:0][DATA_WIDTH-1:0] tdata_in;
  logic [N_INPUTS-1:0]                 tvalid_in;
  logic [N_INPUTS-1:0]                 tready_in;
  logic [DATA_WIDTH-1:0]               tdata_out;
  logic                                tvalid_out;
  logic                                tready_out;

  modport slave (
    input  tdata_in, tvalid_in, tready_out,
    output tready_in, tdata_out, tvalid_out
  );

  modport master (
    output tdata_in, tvalid_in, tready_out,
    input  tready_in, tdata_out, tvalid_out
  );
endinterface

// File: rtl/data_mux_sync.sv
// N:1 link data mux with idle insertion after linkReset, header substitution on orbitSync,
// event-boundary select latching, a 2-entry output skid buffer and a BX/orbit-length check.
module data_mux_sync #(
  parameter int DATA_WIDTH          = 32,
  parameter int N_INPUTS            = 16,
  parameter int SEL_WIDTH           = $clog2(N_INPUTS),
  parameter int IDLE_CNT_WIDTH      = 16,
  parameter int ORBIT_LEN           = 3564,
  parameter int OUTPUT_REVERSE_BITS = 1
) (
  input  logic                      clk,
  input  logic                      aresetn,
  data_mux_sync_if.slave            bus,
  input  logic [IDLE_CNT_WIDTH-1:0] n_idle_words,
  input  logic [SEL_WIDTH-1:0]      output_select,
  input  logic [DATA_WIDTH-1:0]     idle_word,
  input  logic [DATA_WIDTH-1:0]     idle_word_BX0,
  input  logic [DATA_WIDTH-1:0]     header_mask,
  input  logic [DATA_WIDTH-1:0]     header,
  input  logic [DATA_WIDTH-1:0]     header_BX0,
  input  logic                      fc_orbitSync,
  input  logic                      fc_linkReset,
  input  logic                      clear_status,
  output logic [SEL_WIDTH-1:0]      active_select,
  output logic [11:0]               bx_count,
  output logic                      orbit_err
);
  localparam logic [11:0]               BX_LAST = 12'(ORBIT_LEN - 1);
  localparam logic [11:0]               BX_MAX  = 12'hFFF;
  localparam logic [IDLE_CNT_WIDTH-1:0] CNT_ONE = IDLE_CNT_WIDTH'(1);

  logic [DATA_WIDTH-1:0]     buf0, buf1, buf0_n, buf1_n;
  logic [1:0]                fill, fill_n;
  logic                      run;
  logic                      orbit_q, link_q;
  logic                      orbit_pend, reset_pend, orbit_pend_n, reset_pend_n;
  logic [IDLE_CNT_WIDTH-1:0] countdown, countdown_n, cnt_load;
  logic [SEL_WIDTH-1:0]      sel_n;
  logic [11:0]               bx_n;
  logic                      err_n, err_set;
  logic                      orbit_seen, orbit_seen_n;
  logic                      adv, pop, push;
  logic [DATA_WIDTH-1:0]     hdr, cand_word, wr_word;
  logic                      cand_valid;

  // run holds tready_in low for the cycle of reset release so no beat is taken in reset
  assign adv            = run && (fill != 2'd2);
  assign pop            = (fill != 2'd0) && bus.tready_out;
  assign push           = adv && cand_valid;
  assign bus.tready_in  = {N_INPUTS{adv}};
  assign bus.tvalid_out = (fill != 2'd0);
  assign bus.tdata_out  = buf0;

  always_comb begin
    cnt_load    = reset_pend ? n_idle_words : countdown;
    sel_n       = active_select;
    countdown_n = countdown;
    if (adv) begin
      if (reset_pend || (orbit_pend && countdown == '0))
        sel_n = output_select;
      countdown_n = (cnt_load != '0) ? cnt_load - CNT_ONE : cnt_load;
    end

    // the beat that consumes an event already comes from the newly latched select
    hdr        = orbit_pend ? header_BX0 : header;
    cand_word  = idle_word;
    cand_valid = 1'b1;
    if (cnt_load != '0) begin
      cand_word = orbit_pend ? idle_word_BX0 : idle_word;
    end else if (int'(sel_n) < N_INPUTS) begin
      cand_word  = (bus.tdata_in[sel_n] & ~header_mask) | (hdr & header_mask);
      cand_valid = bus.tvalid_in[sel_n];
    end

    wr_word = cand_word;
    if (OUTPUT_REVERSE_BITS != 0) begin
      for (int i = 0; i < DATA_WIDTH; i++)
        wr_word[i] = cand_word[DATA_WIDTH-1-i];
    end
  end

  always_comb begin
    buf0_n = buf0;
    buf1_n = buf1;
    fill_n = fill;
    case ({push, pop})
      2'b10: begin
        if (fill == 2'd0) buf0_n = wr_word;
        else              buf1_n = wr_word;
        fill_n = fill + 2'd1;
      end
      2'b01: begin
        buf0_n = buf1;
        fill_n = fill - 2'd1;
      end
      2'b11: begin
        if (fill == 2'd1) begin
          buf0_n = wr_word;
        end else begin
          buf0_n = buf1;
          buf1_n = wr_word;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    bx_n         = bx_count;
    err_set      = 1'b0;
    orbit_seen_n = orbit_seen;
    if (adv && orbit_pend) begin
      err_set      = orbit_seen && (bx_count != BX_LAST);
      orbit_seen_n = 1'b1;
      bx_n         = push ? 12'd1 : 12'd0;
    end else if (push && bx_count != BX_MAX) begin
      bx_n = bx_count + 12'd1;
    end
    err_n = err_set ? 1'b1 : (clear_status ? 1'b0 : orbit_err);

    // an edge arriving on the consuming cycle is a new event and must survive
    orbit_pend_n = (fc_orbitSync & ~orbit_q) ? 1'b1 : (adv ? 1'b0 : orbit_pend);
    reset_pend_n = (fc_linkReset & ~link_q)  ? 1'b1 : (adv ? 1'b0 : reset_pend);
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      buf0          <= '0;
      buf1          <= '0;
      fill          <= 2'd0;
      run           <= 1'b0;
      orbit_q       <= fc_orbitSync;
      link_q        <= fc_linkReset;
      orbit_pend    <= 1'b0;
      reset_pend    <= 1'b0;
      countdown     <= '0;
      active_select <= '0;
      bx_count      <= '0;
      orbit_err     <= 1'b0;
      orbit_seen    <= 1'b0;
    end else begin
      buf0          <= buf0_n;
      buf1          <= buf1_n;
      fill          <= fill_n;
      run           <= 1'b1;
      orbit_q       <= fc_orbitSync;
      link_q        <= fc_linkReset;
      orbit_pend    <= orbit_pend_n;
      reset_pend    <= reset_pend_n;
      countdown     <= countdown_n;
      active_select <= sel_n;
      bx_count      <= bx_n;
      orbit_err     <= err_n;
      orbit_seen    <= orbit_seen_n;
    end
  end
endmodule
